// File: rtl/sa_ctrl.sv
// sa_ctrl: tile sequencer for an N x N output-stationary systolic array (clear, feed, drain, readout).
// Define SA_CTRL_PERF_CNT_EN to build the saturating busy-cycle counter behind cycle_cnt_o.
module sa_ctrl #(
  parameter int N       = 4,
  parameter int K_WIDTH = 8,
  parameter int RD_LAT  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [K_WIDTH-1:0]   k_len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 rd_en_o,
  output logic [K_WIDTH-1:0]   rd_addr_o,
  output logic [N-1:0]         a_valid_o,
  output logic [N-1:0]         b_valid_o,
  output logic                 a_clr_o,
  output logic                 b_clr_o,
  output logic                 acc_clr_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [$clog2(N)-1:0] out_row_o,
  output logic [31:0]          cycle_cnt_o
);

  localparam int ROW_W     = $clog2(N);
  localparam int DRAIN_CYC = 2 * N + RD_LAT;
  localparam int DRAIN_W   = $clog2(DRAIN_CYC);
  localparam int SKEW_LEN  = RD_LAT + N - 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    READOUT
  } state_e;

  state_e              state_q, state_d;
  logic [K_WIDTH-1:0]  k_q, k_d;
  logic [K_WIDTH-1:0]  addr_q, addr_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                done_q, done_d;
  logic [SKEW_LEN-1:0] skew_q, skew_d;
  logic                feed_last;
  logic                drain_last;
  logic                row_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      drain_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      skew_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      row_q   <= row_d;
      done_q  <= done_d;
      skew_q  <= skew_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    addr_d     = addr_q;
    drain_d    = drain_q;
    row_d      = row_q;
    done_d     = 1'b0;
    feed_last  = (addr_q == (k_q - K_WIDTH'(1)));
    drain_last = (drain_q == DRAIN_W'(DRAIN_CYC - 1));
    row_last   = (row_q == ROW_W'(N - 1));
    // The skew line keeps shifting in every state so it empties itself during DRAIN.
    skew_d     = {skew_q[SKEW_LEN-2:0], (state_q == FEED)};

    case (state_q)
      IDLE: begin
        if (start_i && (k_len_i != '0)) begin
          state_d = CLEAR;
          k_d     = k_len_i;
        end
      end
      CLEAR: begin
        state_d = FEED;
        addr_d  = '0;
      end
      FEED: begin
        if (feed_last) begin
          state_d = DRAIN;
          addr_d  = '0;
          drain_d = '0;
        end else begin
          addr_d = addr_q + K_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (drain_last) begin
          state_d = READOUT;
          drain_d = '0;
          row_d   = '0;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      READOUT: begin
        if (out_ready_i) begin
          if (row_last) begin
            state_d = IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign rd_en_o     = (state_q == FEED);
  assign rd_addr_o   = rd_en_o ? addr_q : '0;
  assign a_clr_o     = (state_q == CLEAR);
  assign b_clr_o     = (state_q == CLEAR);
  assign acc_clr_o   = (state_q == CLEAR);
  assign out_valid_o = (state_q == READOUT);
  assign out_row_o   = row_q;

  // Row r and column c see the same read-enable delayed by RD_LAT + index.
  for (genvar i = 0; i < N; i++) begin : g_skew
    assign a_valid_o[i] = skew_q[RD_LAT+i-1];
    assign b_valid_o[i] = skew_q[RD_LAT+i-1];
  end

`ifdef SA_CTRL_PERF_CNT_EN
  logic        start_acc;
  logic [31:0] cyc_q, cyc_d;

  assign start_acc = (state_q == IDLE) && start_i && (k_len_i != '0);

  always_comb begin
    cyc_d = cyc_q;
    if (start_acc) begin
      cyc_d = '0;
    end else if (busy_o && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cycle_cnt_o = cyc_q;
`else
  assign cycle_cnt_o = '0;
`endif

endmodule

// File: doc/sa_ctrl.md
# sa_ctrl

Sequencer for an N x N output-stationary systolic array built from `mac_pe` tiles. One accepted start runs a full matrix tile:
- clear the accumulators;
- stream K operand pairs from the A/B operand buffers with per-row/per-column skew;
- drain the pipeline;
- hand the N result rows out over a valid/ready port.

It sits between the tile scheduler (start/done) and the array plus its operand buffers.

## Interface
- `N`, 4, array dimension (rows = cols), ≥2
- `K_WIDTH`, 8, width of K length and buffer read address
- `RD_LAT`, 1, operand buffer read latency in cycles, ≥1
- `clk_i`  in  1  clock, all logic on rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `start_i`  in  1  start request, sampled only in IDLE
- `k_len_i`  in  K_WIDTH  number of K steps, latched on start acceptance
- `busy_o`  out  1  high whenever state ≠ IDLE
- `done_o`  out  1  one-cycle pulse after last result row accepted
- `rd_en_o`  out  1  operand buffer read enable (A and B buffers share it)
- `rd_addr_o`  out  K_WIDTH  operand buffer read address
- `a_valid_o`  out  N  per-row `a_valid_i` of array west-edge PEs
- `b_valid_o`  out  N  per-column `b_valid_i` of array north-edge PEs
- `a_clr_o`, `b_clr_o`, `acc_clr_o`  out  1 each  broadcast clears to all PEs
- `out_valid_o`  out  1  result row available
- `out_ready_i`  in  1  result consumer ready
- `out_row_o`  out  $clog2(N)  index of result row presented
- `cycle_cnt_o`  out  32  busy-cycle counter (see Configuration)

## Operation
- One clock `clk_i`; reset `rst_ni` is asynchronous, active-low.
- States: IDLE, CLEAR, FEED, DRAIN, READOUT.
- IDLE:
  - `start_i`=1 and `k_len_i`≠0 → CLEAR; latch `k_len_i`.
  - `start_i` with `k_len_i`=0 is ignored: stay IDLE, no `done_o`.
- CLEAR: exactly 1 cycle. `a_clr_o`=`b_clr_o`=`acc_clr_o`=1. → FEED.
- FEED: exactly k cycles. `rd_en_o`=1, `rd_addr_o` = 0,1,…,k−1. → DRAIN after address k−1.
- DRAIN: exactly 2·N+RD_LAT cycles, counted by an internal counter. → READOUT.
- READOUT:
  - `out_valid_o`=1; `out_row_o` starts at 0.
  - Row advances on each cycle with `out_valid_o`&&`out_ready_i`.
  - Handshake on row N−1 → IDLE, with `done_o`=1 in the first IDLE cycle.
- Skew:
  - `a_valid_o[r]` = `rd_en_o` delayed RD_LAT+r cycles.
  - `b_valid_o[c]` = `rd_en_o` delayed RD_LAT+c cycles.
  - Implemented as shift registers that keep shifting through DRAIN, so all valids are 0 before READOUT.
- `start_i` outside IDLE is ignored.
- `out_valid_o` must not drop in READOUT until its handshake completes; `out_row_o` holds stable while stalled.
- `rd_addr_o` is 0 when `rd_en_o`=0.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Reset value of every output is 0 (`busy_o`, `done_o`, `rd_en_o`, `rd_addr_o`, all valids and clears, `out_valid_o`, `out_row_o`, `cycle_cnt_o`). State = IDLE, skew registers cleared.
- Reset mid-operation aborts the tile immediately; no `done_o` is issued.
- Cycle numbering, with start sampled at edge of cycle 0:
  - CLEAR = cycle 1.
  - FEED = cycles 2..k+1.
  - DRAIN = cycles k+2..k+1+2N+RD_LAT.
  - READOUT from cycle k+2+2N+RD_LAT.
- Minimum start-to-done: k+2+2N+RD_LAT+N cycles, with `out_ready_i` held high.
- `done_o` and a new start can coincide: start in the `done_o` cycle is accepted.

## Configuration
- `SA_CTRL_PERF_CNT_EN` defined:
  - `cycle_cnt_o` clears to 0 on start acceptance.
  - It increments every cycle `busy_o`=1 and holds its value in IDLE until the next start.
  - It saturates at 2^32−1.
- Not defined: `cycle_cnt_o` is tied to 0 and no counter flops are instantiated. The port is kept for interface stability.

## Test plan
- Reset: hold `rst_ni`=0 for 3 cycles → every output 0; state IDLE; `busy_o`=0.
- Nominal tile, N=4, RD_LAT=1, k=3, `out_ready_i`=1:
  - clears high in cycle 1; `rd_addr_o` 0,1,2 in cycles 2–4.
  - `a_valid_o[3]` high cycles 6–8.
  - `out_valid_o` cycles 14–17 with rows 0–3; `done_o` in cycle 18.
- Backpressure: same tile, `out_ready_i`=0 for cycles 14–16 → row 0 held stable; rows advance from cycle 17; `done_o` in cycle 21.
- Ignored starts:
  - `k_len_i`=0 with `start_i`=1 → no state change.
  - `start_i` pulsed during FEED → no effect on the running tile.
- Reset mid-FEED: drop `rst_ni` in cycle 3 → all outputs 0 asynchronously; no `done_o`. A new k=2 start after release completes normally.
- With `SA_CTRL_PERF_CNT_EN`, k=3 tile, no backpressure → `cycle_cnt_o`=17 after `done_o`. Without the macro → 0.
